// File: rtl/fpcvt_pipe_if.sv
// Handshake bundle for fpcvt_pipe.
//   Upstream side  : in_valid, in_ready, in_data (two's complement), in_trunc
//   Downstream side: out_valid, out_ready, out_s, out_e, out_f, out_sat
// The slave modport is the converter's view; the master modport is the view
// of whoever drives samples in and consumes results.
interface fpcvt_pipe_if #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              in_trunc;
    logic              out_valid;
    logic              out_ready;
    logic              out_s;
    logic [EXP_W-1:0]  out_e;
    logic [MAN_W-1:0]  out_f;
    logic              out_sat;

    modport slave (
        input  in_valid, in_data, in_trunc, out_ready,
        output in_ready, out_valid, out_s, out_e, out_f, out_sat
    );

    modport master (
        output in_valid, in_data, in_trunc, out_ready,
        input  in_ready, out_valid, out_s, out_e, out_f, out_sat
    );
endinterface

// File: rtl/fpcvt_pipe.sv
// Pipelined two's-complement to small floating-point converter.
// Value represented = (-1)^out_s * out_f * 2^out_e.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fpcvt_pipe_if.slave (valid/ready in, valid/ready out, result fields)
// Stage 1 takes sign/magnitude, stage 2 normalises, stage 3 rounds.
// Each stage has its own valid bit and advances when its successor is empty
// or advancing, so the pipe runs at one sample per cycle and holds up to
// three samples under backpressure.
module fpcvt_pipe #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fpcvt_pipe_if.slave   bus
);
    localparam int M = IN_W - 1;

    // The largest shift (M-MAN_W) must be representable in the exponent.
    generate
        if ((M - MAN_W) > ((1 << EXP_W) - 1) || MAN_W < 2 || MAN_W >= M) begin : g_bad_params
            $error("fpcvt_pipe: illegal IN_W/EXP_W/MAN_W combination");
        end
    endgenerate

    // Stage registers
    logic              r_v1, r_v2, r_v3;
    logic              r_s1, r_sat1, r_trunc1;
    logic [M-1:0]      r_mag1;
    logic              r_s2, r_sat2, r_trunc2, r_r2;
    logic [EXP_W-1:0]  r_e2;
    logic [MAN_W-1:0]  r_f2;
    logic              r_s3, r_sat3;
    logic [EXP_W-1:0]  r_e3;
    logic [MAN_W-1:0]  r_f3;

    // Pipeline advance: a stage may load when it is empty or its content
    // moves on this cycle.
    logic w_en1, w_en2, w_en3;
    assign w_en3 = ~r_v3 | bus.out_ready;
    assign w_en2 = ~r_v2 | w_en3;
    assign w_en1 = ~r_v1 | w_en2;

    assign bus.in_ready  = w_en1;
    assign bus.out_valid = r_v3;
    assign bus.out_s     = r_s3;
    assign bus.out_e     = r_e3;
    assign bus.out_f     = r_f3;
    assign bus.out_sat   = r_sat3;

    // Stage 1: sign/magnitude. -2^M has no positive M-bit magnitude, so it
    // clamps to all-ones and is flagged.
    logic            w_s1, w_min1;
    logic [IN_W-1:0] w_abs1;
    logic [M-1:0]    w_mag1;
    assign w_s1   = bus.in_data[IN_W-1];
    assign w_abs1 = w_s1 ? (~bus.in_data + 1'b1) : bus.in_data;
    assign w_min1 = w_s1 && (bus.in_data[M-1:0] == '0);
    assign w_mag1 = w_min1 ? '1 : w_abs1[M-1:0];

    // Stage 2: normalise on the leading one. Small magnitudes pass through
    // exactly with E = 0; otherwise keep MAN_W bits below and including the
    // leading one and remember the first dropped bit for rounding.
    int                w_p2;
    logic [M-1:0]      w_norm2;
    logic [EXP_W-1:0]  w_e2;
    logic [MAN_W-1:0]  w_f2;
    logic              w_r2;

    // NOTE: every combinational output gets a default at the top of the
    // block; a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_p2    = 0;
        w_norm2 = '0;
        w_e2    = '0;
        w_f2    = r_mag1[MAN_W-1:0];
        w_r2    = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (r_mag1[i]) w_p2 = i;
        end
        if (w_p2 >= MAN_W) begin
            // Shift so the leading one lands at bit MAN_W, rounding bit at 0.
            w_norm2 = r_mag1 >> (w_p2 - MAN_W);
            w_e2    = EXP_W'(w_p2 - MAN_W + 1);
            w_f2    = w_norm2[MAN_W:1];
            w_r2    = w_norm2[0];
        end
    end

    // Stage 3: round half away from zero on the magnitude. A carry out of
    // the significand renormalises to 100..0 and bumps the exponent; at the
    // top exponent the value is clamped and flagged instead.
    logic [EXP_W-1:0]  w_e3;
    logic [MAN_W-1:0]  w_f3;
    logic              w_sat3;

    always_comb begin
        w_e3   = r_e2;
        w_f3   = r_f2;
        w_sat3 = r_sat2;
        if (!r_trunc2 && r_r2) begin
            if (!(&r_f2)) begin
                w_f3 = r_f2 + 1'b1;
            end else if (!(&r_e2)) begin
                w_f3 = {1'b1, {(MAN_W-1){1'b0}}};
                w_e3 = r_e2 + 1'b1;
            end else begin
                w_sat3 = 1'b1;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every stage sees
    // the previous-cycle value of its predecessor regardless of order.
    // NOTE: datapath registers are reset as well as the valid bits because
    // the result fields must read zero during and right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_s1     <= 1'b0;
            r_sat1   <= 1'b0;
            r_trunc1 <= 1'b0;
            r_mag1   <= '0;
            r_s2     <= 1'b0;
            r_sat2   <= 1'b0;
            r_trunc2 <= 1'b0;
            r_r2     <= 1'b0;
            r_e2     <= '0;
            r_f2     <= '0;
            r_s3     <= 1'b0;
            r_sat3   <= 1'b0;
            r_e3     <= '0;
            r_f3     <= '0;
        end else begin
            if (w_en1) begin
                r_v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1     <= w_s1;
                    r_mag1   <= w_mag1;
                    r_sat1   <= w_min1;
                    r_trunc1 <= bus.in_trunc;
                end
            end
            if (w_en2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_s2     <= r_s1;
                    r_sat2   <= r_sat1;
                    r_trunc2 <= r_trunc1;
                    r_e2     <= w_e2;
                    r_f2     <= w_f2;
                    r_r2     <= w_r2;
                end
            end
            if (w_en3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_s3   <= r_s2;
                    r_e3   <= w_e3;
                    r_f3   <= w_f3;
                    r_sat3 <= w_sat3;
                end
            end
        end
    end
endmodule

// File: tb/tb_fpcvt_pipe.sv
// Directed and sweep testbench for fpcvt_pipe (IN_W=12, EXP_W=3, MAN_W=4).
module tb_fpcvt_pipe;
    localparam int IN_W  = 12;
    localparam int EXP_W = 3;
    localparam int MAN_W = 4;

    typedef struct packed {
        logic       s;
        logic [2:0] e;
        logic [3:0] f;
        logic       sat;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fpcvt_pipe_if #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fpcvt_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: find the smallest shift that fits the magnitude in 4 bits,
    // then round by adding the first dropped bit and renormalising.
    function automatic res_t model(input logic [11:0] d, input logic t);
        int   v, mag, e, f, r;
        res_t o;
        v     = $signed(d);
        o.s   = (v < 0);
        mag   = (v < 0) ? -v : v;
        o.sat = 1'b0;
        if (mag > 2047) begin
            mag   = 2047;
            o.sat = 1'b1;
        end
        e = 0;
        while ((mag >> e) > 15) e++;
        f = mag >> e;
        r = (e > 0) ? ((mag >> (e - 1)) & 1) : 0;
        if (!t && r == 1) begin
            f = f + 1;
            if (f == 16) begin
                f = 8;
                e = e + 1;
            end
            if (e > 7) begin
                e     = 7;
                f     = 15;
                o.sat = 1'b1;
            end
        end
        o.e = 3'(e);
        o.f = 4'(f);
        return o;
    endfunction

    function automatic res_t observed();
        return {bus.out_s, bus.out_e, bus.out_f, bus.out_sat};
    endfunction

    // Present one sample and wait (bounded) until it is accepted.
    task automatic push(input logic [11:0] d, input logic t, output bit ok);
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_trunc = t;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // One sample through an idle pipe with out_ready high: checks latency
    // and the result fields against a hand-computed value.
    task automatic run_single(input string name, input logic [11:0] d, input logic t,
                              input res_t exp);
        bit   ok;
        int   lat;
        res_t got;
        bus.out_ready = 1'b1;
        push(d, t, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s accept: in_ready never seen", name);
        end
        lat = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
        total++;
        if (lat !== 3 || !bus.out_valid) begin
            bad++;
            $display("FAIL %s latency: got %0d (valid=%0b) expected 3", name, lat, bus.out_valid);
        end
        got = observed();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s value: got s=%0b e=%0d f=%0d sat=%0b expected s=%0b e=%0d f=%0d sat=%0b",
                     name, got.s, got.e, got.f, got.sat, exp.s, exp.e, exp.f, exp.sat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_trunc  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || observed() !== '0) begin
            bad++;
            $display("FAIL reset outputs: valid=%0b fields=%h expected 0", bus.out_valid, observed());
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset in_ready: got %0b expected 1", bus.in_ready);
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset out_valid after release: got %0b expected 0", bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        run_single("zero",  12'd0,              1'b0, '{s:1'b0, e:3'd0, f:4'd0,  sat:1'b0});
        run_single("neg7",  12'hFF9,            1'b0, '{s:1'b1, e:3'd0, f:4'd7,  sat:1'b0});
        run_single("pos56", 12'd56,             1'b0, '{s:1'b0, e:3'd2, f:4'd14, sat:1'b0});
    endtask

    task automatic test_rounding();
        run_single("62_round", 12'd62, 1'b0, '{s:1'b0, e:3'd3, f:4'd8,  sat:1'b0});
        run_single("62_trunc", 12'd62, 1'b1, '{s:1'b0, e:3'd2, f:4'd15, sat:1'b0});
    endtask

    task automatic test_saturation();
        run_single("2047_round", 12'd2047, 1'b0, '{s:1'b0, e:3'd7, f:4'd15, sat:1'b1});
        run_single("2047_trunc", 12'd2047, 1'b1, '{s:1'b0, e:3'd7, f:4'd15, sat:1'b0});
        run_single("min_neg",    12'h800,  1'b0, '{s:1'b1, e:3'd7, f:4'd15, sat:1'b1});
    endtask

    // 8 back-to-back samples, out_ready low in stream cycles 4..9.
    task automatic test_backpressure();
        logic [11:0] din [8];
        logic        tin [8];
        res_t        q[$];
        res_t        held, got, exp;
        int          sent, done, cyc;
        bit          was_stall, saw_block;
        for (int k = 0; k < 8; k++) begin
            din[k] = 12'(k * 291 - 900);
            tin[k] = k[0];
        end
        sent = 0; done = 0; cyc = 0; was_stall = 0; saw_block = 0;
        while (done < 8 && cyc < 100) begin
            bus.in_valid  = (sent < 8);
            bus.in_data   = din[sent < 8 ? sent : 7];
            bus.in_trunc  = tin[sent < 8 ? sent : 7];
            bus.out_ready = !(cyc >= 4 && cyc <= 9);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(din[sent], tin[sent]));
                sent++;
            end else if (bus.in_valid && !bus.in_ready && !saw_block) begin
                saw_block = 1;
                total++;
                if (sent - done != 3) begin
                    bad++;
                    $display("FAIL bp block depth: got %0d held expected 3", sent - done);
                end
            end
            if (bus.out_valid) begin
                got = observed();
                if (was_stall) begin
                    total++;
                    if (got !== held) begin
                        bad++;
                        $display("FAIL bp stable: got %h expected %h", got, held);
                    end
                end
                if (bus.out_ready) begin
                    exp = (q.size() > 0) ? q.pop_front() : '0;
                    total++;
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL bp result %0d: got %h expected %h", done, got, exp);
                    end
                    done++;
                    was_stall = 0;
                end else begin
                    held      = got;
                    was_stall = 1;
                end
            end else begin
                was_stall = 0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        total++;
        if (done !== 8 || !saw_block) begin
            bad++;
            $display("FAIL bp completion: got %0d results block=%0b expected 8 block=1", done, saw_block);
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        bus.out_ready = 1'b0;
        push(12'd300, 1'b0, ok);
        push(12'hF00, 1'b0, ok);
        push(12'd77,  1'b1, ok);
        total++;
        if (!ok || !bus.out_valid) begin
            bad++;
            $display("FAIL midflight fill: accepted=%0b out_valid=%0b expected 1 1", ok, bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || observed() !== '0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midflight reset: valid=%0b fields=%h in_ready=%0b expected 0 0 1",
                     bus.out_valid, observed(), bus.in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL midflight stale: out_valid got %0b expected 0", bus.out_valid);
        end
        @(posedge clk);
        #1;
        run_single("after_reset_100", 12'd100, 1'b0, '{s:1'b0, e:3'd3, f:4'd13, sat:1'b0});
    endtask

    // Every input code in both modes with random downstream stalls.
    task automatic test_sweep();
        res_t q[$];
        res_t got, exp;
        int   sent, done, cyc, errs;
        sent = 0; done = 0; cyc = 0; errs = 0;
        while (done < 8192 && cyc < 40000) begin
            bus.in_valid  = (sent < 8192);
            bus.in_data   = 12'(sent);
            bus.in_trunc  = (sent >= 4096);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(12'(sent), sent >= 4096));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                got = observed();
                exp = (q.size() > 0) ? q.pop_front() : '0;
                total++;
                if (got !== exp) begin
                    bad++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL sweep result %0d: got %h expected %h", done, got, exp);
                end
                done++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        total++;
        if (done !== 8192) begin
            bad++;
            $display("FAIL sweep count: got %0d results expected 8192", done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_reset_midflight();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
